// File: rtl/cv32e40s_miter_obi_checker_if.sv
// cv32e40s_miter_obi_checker_if: OBI data-side and alert signals of both lockstep core copies
interface cv32e40s_miter_obi_checker_if;
  logic        data_req_o_1, data_req_o_2;
  logic        data_gnt_i_1, data_gnt_i_2;
  logic [31:0] data_addr_o_1, data_addr_o_2;
  logic        data_we_o_1, data_we_o_2;
  logic [3:0]  data_be_o_1, data_be_o_2;
  logic [31:0] data_wdata_o_1, data_wdata_o_2;
  logic        alert_major_o_1, alert_major_o_2;
  modport master (
    output data_req_o_1, data_req_o_2, data_gnt_i_1, data_gnt_i_2,
           data_addr_o_1, data_addr_o_2, data_we_o_1, data_we_o_2,
           data_be_o_1, data_be_o_2, data_wdata_o_1, data_wdata_o_2,
           alert_major_o_1, alert_major_o_2
  );
  modport slave (
    input data_req_o_1, data_req_o_2, data_gnt_i_1, data_gnt_i_2,
          data_addr_o_1, data_addr_o_2, data_we_o_1, data_we_o_2,
          data_be_o_1, data_be_o_2, data_wdata_o_1, data_wdata_o_2,
          alert_major_o_1, alert_major_o_2
  );
endinterface

// File: rtl/cv32e40s_miter_obi_checker.sv
// cv32e40s_miter_obi_checker: pairs accepted OBI data transactions of two core copies and flags divergence.
// Optional macro MITER_OBI_WDATA_CMP_EN adds write-data storage and comparison.
module cv32e40s_miter_obi_checker #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                              clk,
  input  logic                              rst,
  cv32e40s_miter_obi_checker_if.slave       obi,
  output logic                              mismatch_o,
  output logic                              lag_err_o,
  output logic                              alert_diff_o,
  output logic                              fail_o,
  output logic [CNT_W-1:0]                  txn_cnt_o,
  output logic [31:0]                       fail_addr_1_o,
  output logic [31:0]                       fail_addr_2_o
);
  localparam int AW = $clog2(DEPTH);
`ifdef MITER_OBI_WDATA_CMP_EN
  localparam int EW = 69;
`else
  localparam int EW = 37;
`endif
  typedef enum logic {CHECK, FAIL} state_e;
  state_e           state_q;
  logic [EW-1:0]    mem1_q [DEPTH];
  logic [EW-1:0]    mem2_q [DEPTH];
  logic [AW:0]      wp1_q, rp1_q, wp2_q, rp2_q;
  logic             mismatch_q, lag_q, alert_diff_q;
  logic [CNT_W-1:0] cnt_q;
  logic [31:0]      fa1_q, fa2_q;
  logic [EW-1:0]    e1, e2, h1, h2;
  logic             chk, empty1, empty2, full1, full2, acc1, acc2, pop, psh1, psh2;
  logic             pair_mis, mis_ev, lag_ev, ad_ev;
`ifdef MITER_OBI_WDATA_CMP_EN
  assign e1 = {obi.data_addr_o_1, obi.data_we_o_1, obi.data_be_o_1, obi.data_wdata_o_1};
  assign e2 = {obi.data_addr_o_2, obi.data_we_o_2, obi.data_be_o_2, obi.data_wdata_o_2};
  // differing we already mismatches, so checking side 1's we is enough
  assign pair_mis = (h1[EW-1 -: 37] != h2[EW-1 -: 37]) | (h1[EW-33] & (h1[31:0] != h2[31:0]));
`else
  logic unused_wdata;
  assign unused_wdata = ^{obi.data_wdata_o_1, obi.data_wdata_o_2};
  assign e1 = {obi.data_addr_o_1, obi.data_we_o_1, obi.data_be_o_1};
  assign e2 = {obi.data_addr_o_2, obi.data_we_o_2, obi.data_be_o_2};
  assign pair_mis = h1 != h2;
`endif
  assign h1     = mem1_q[rp1_q[AW-1:0]];
  assign h2     = mem2_q[rp2_q[AW-1:0]];
  assign chk    = state_q == CHECK;
  assign empty1 = wp1_q == rp1_q;
  assign empty2 = wp2_q == rp2_q;
  assign full1  = wp1_q == {~rp1_q[AW], rp1_q[AW-1:0]};
  assign full2  = wp2_q == {~rp2_q[AW], rp2_q[AW-1:0]};
  assign acc1   = chk & obi.data_req_o_1 & obi.data_gnt_i_1;
  assign acc2   = chk & obi.data_req_o_2 & obi.data_gnt_i_2;
  assign pop    = chk & ~empty1 & ~empty2;
  assign psh1   = acc1 & (~full1 | pop);
  assign psh2   = acc2 & (~full2 | pop);
  assign mis_ev = pop & pair_mis;
  assign lag_ev = ((acc1 & full1) | (acc2 & full2)) & ~pop;
  assign ad_ev  = obi.alert_major_o_1 != obi.alert_major_o_2;
  always_ff @(posedge clk) begin
    if (psh1) mem1_q[wp1_q[AW-1:0]] <= e1;
    if (psh2) mem2_q[wp2_q[AW-1:0]] <= e2;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= CHECK;
      wp1_q        <= '0;
      rp1_q        <= '0;
      wp2_q        <= '0;
      rp2_q        <= '0;
      mismatch_q   <= 1'b0;
      lag_q        <= 1'b0;
      alert_diff_q <= 1'b0;
      cnt_q        <= '0;
      fa1_q        <= '0;
      fa2_q        <= '0;
    end else begin
      if (psh1) wp1_q <= wp1_q + (AW+1)'(1);
      if (psh2) wp2_q <= wp2_q + (AW+1)'(1);
      if (pop) begin
        rp1_q <= rp1_q + (AW+1)'(1);
        rp2_q <= rp2_q + (AW+1)'(1);
      end
      mismatch_q   <= mismatch_q | mis_ev;
      lag_q        <= lag_q | lag_ev;
      alert_diff_q <= alert_diff_q | ad_ev;
      // pops only happen in CHECK and any mismatch leaves CHECK, so this fires once
      if (mis_ev) begin
        fa1_q <= h1[EW-1 -: 32];
        fa2_q <= h2[EW-1 -: 32];
      end
      if (pop & ~pair_mis & (cnt_q != '1)) cnt_q <= cnt_q + CNT_W'(1);
      if (mis_ev | lag_ev | ad_ev) state_q <= FAIL;
    end
  end
  assign mismatch_o    = mismatch_q;
  assign lag_err_o     = lag_q;
  assign alert_diff_o  = alert_diff_q;
  assign fail_o        = state_q == FAIL;
  assign txn_cnt_o     = cnt_q;
  assign fail_addr_1_o = fa1_q;
  assign fail_addr_2_o = fa2_q;
endmodule

// File: tb/tb_cv32e40s_miter_obi_checker.sv
// tb_cv32e40s_miter_obi_checker: directed scoreboard bench; a second instance with CNT_W=2 exercises counter saturation.
module tb_cv32e40s_miter_obi_checker;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  cv32e40s_miter_obi_checker_if obi();
  logic        mis, lag, ad, fail, mis_s, lag_s, ad_s, fail_s;
  logic [15:0] cnt;
  logic [1:0]  cnt_s;
  logic [31:0] fa1, fa2, fa1_s, fa2_s;
  cv32e40s_miter_obi_checker #(.DEPTH(4), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .obi(obi.slave), .mismatch_o(mis), .lag_err_o(lag),
    .alert_diff_o(ad), .fail_o(fail), .txn_cnt_o(cnt), .fail_addr_1_o(fa1), .fail_addr_2_o(fa2)
  );
  cv32e40s_miter_obi_checker #(.DEPTH(4), .CNT_W(2)) dut_s (
    .clk(clk), .rst(rst), .obi(obi.slave), .mismatch_o(mis_s), .lag_err_o(lag_s),
    .alert_diff_o(ad_s), .fail_o(fail_s), .txn_cnt_o(cnt_s), .fail_addr_1_o(fa1_s), .fail_addr_2_o(fa2_s)
  );
  typedef struct {int due; string name; logic [85:0] exp;} exp_t;
  exp_t q[$];
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  logic [85:0] act;
  assign act = {mis, lag, ad, fail, cnt, cnt_s, fa1, fa2};
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].due <= cyc) begin
      exp_t e;
      e = q.pop_front();
      checks++;
      if (act !== e.exp) begin
        errors++;
        $display("FAIL %s: got %h expected %h (mis,lag,ad,fail,cnt,cnt_s,fa1,fa2)", e.name, act, e.exp);
      end
    end
  end
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic clr;
    obi.data_req_o_1 = 0; obi.data_req_o_2 = 0; obi.data_gnt_i_1 = 0; obi.data_gnt_i_2 = 0;
    obi.data_addr_o_1 = 0; obi.data_addr_o_2 = 0; obi.data_we_o_1 = 0; obi.data_we_o_2 = 0;
    obi.data_be_o_1 = 0; obi.data_be_o_2 = 0; obi.data_wdata_o_1 = 0; obi.data_wdata_o_2 = 0;
    obi.alert_major_o_1 = 0; obi.alert_major_o_2 = 0;
  endtask
  task automatic side(input int k, input logic [31:0] a, input logic w, input logic [3:0] b, input logic [31:0] d);
    if (k == 1) begin
      obi.data_req_o_1 = 1; obi.data_gnt_i_1 = 1; obi.data_addr_o_1 = a;
      obi.data_we_o_1 = w; obi.data_be_o_1 = b; obi.data_wdata_o_1 = d;
    end else begin
      obi.data_req_o_2 = 1; obi.data_gnt_i_2 = 1; obi.data_addr_o_2 = a;
      obi.data_we_o_2 = w; obi.data_be_o_2 = b; obi.data_wdata_o_2 = d;
    end
  endtask
  task automatic chk(input string n, input logic m, input logic l, input logic a, input logic f,
                     input logic [15:0] c, input logic [1:0] cs, input logic [31:0] f1, input logic [31:0] f2);
    exp_t e;
    e.due = cyc;
    e.name = n;
    e.exp = {m, l, a, f, c, cs, f1, f2};
    q.push_back(e);
  endtask
  task automatic rst_cycle;
    clr;
    rst = 1;
    step;
    rst = 0;
  endtask
  initial begin
    clr;
    rst = 1;
    repeat (2) step;
    rst = 0;
    chk("reset", 0, 0, 0, 0, 0, 0, 0, 0);
    side(1, 'h100, 1, 'hF, 'h11); side(2, 'h100, 1, 'hF, 'h11); step; clr; step;
    chk("one_pair", 0, 0, 0, 0, 1, 1, 0, 0);
    repeat (2) begin side(1, 'h100, 1, 'hF, 'h11); side(2, 'h100, 1, 'hF, 'h11); step; end
    clr; step;
    chk("three_pairs", 0, 0, 0, 0, 3, 3, 0, 0);
    side(1, 'h100, 1, 'hF, 'h11); side(2, 'h100, 1, 'hF, 'h11); step; clr; step;
    chk("saturate", 0, 0, 0, 0, 4, 3, 0, 0);
    obi.data_req_o_1 = 1; obi.data_req_o_2 = 1; obi.data_addr_o_1 = 'h500; obi.data_addr_o_2 = 'h600;
    step; clr; step;
    chk("no_gnt", 0, 0, 0, 0, 4, 3, 0, 0);
    obi.alert_major_o_1 = 1; step; clr;
    chk("alert_diff", 0, 0, 1, 1, 4, 3, 0, 0);
    rst_cycle;
    chk("alert_rst", 0, 0, 0, 0, 0, 0, 0, 0);
    side(1, 'h200, 0, 'hF, 0); side(2, 'h204, 0, 'hF, 0); step; clr;
    chk("mis_pre", 0, 0, 0, 0, 0, 0, 0, 0);
    step;
    chk("mismatch", 1, 0, 0, 1, 0, 0, 'h200, 'h204);
    side(1, 'h300, 0, 'hF, 0); side(2, 'h304, 0, 'hF, 0); step; clr; repeat (2) step;
    chk("mis_hold", 1, 0, 0, 1, 0, 0, 'h200, 'h204);
    rst_cycle;
    for (int i = 0; i < 4; i++) begin side(1, i * 4, 0, 'hF, 0); step; end
    clr; step;
    chk("lag_4", 0, 0, 0, 0, 0, 0, 0, 0);
    side(1, 'h10, 0, 'hF, 0); step; clr;
    chk("lag_5", 0, 1, 0, 1, 0, 0, 0, 0);
    rst_cycle;
    chk("lag_rst", 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      clr; side(1, i * 4, 0, 'hF, 0);
      if (i == 3) side(2, 0, 0, 'hF, 0);
      step;
    end
    clr; side(1, 'h10, 0, 'hF, 0); side(2, 'h4, 0, 'hF, 0); step;
    chk("full_push_pop", 0, 0, 0, 0, 1, 1, 0, 0);
    for (int i = 2; i < 5; i++) begin clr; side(2, i * 4, 0, 'hF, 0); step; end
    clr; step;
    chk("full_drain", 0, 0, 0, 0, 5, 3, 0, 0);
    rst_cycle;
    side(1, 'h700, 0, 'hF, 0); step; side(1, 'h704, 0, 'hF, 0); step; rst_cycle;
    side(2, 'h800, 0, 'hF, 0); step; side(2, 'h804, 0, 'hF, 0); step; clr; step;
    chk("discard", 0, 0, 0, 0, 0, 0, 0, 0);
    side(1, 'h800, 0, 'hF, 0); step; side(1, 'h804, 0, 'hF, 0); step; clr; step;
    chk("post_rst", 0, 0, 0, 0, 2, 2, 0, 0);
    rst_cycle;
    side(1, 'h400, 0, 'hF, 'h1); side(2, 'h400, 0, 'hF, 'h2); step; clr; step;
    chk("rd_wdata", 0, 0, 0, 0, 1, 1, 0, 0);
    side(1, 'h400, 1, 'hF, 'hDEADBEEF); side(2, 'h400, 1, 'hF, 'hDEADBEEE); step; clr; step;
`ifdef MITER_OBI_WDATA_CMP_EN
    chk("wr_wdata", 1, 0, 0, 1, 1, 1, 'h400, 'h400);
`else
    chk("wr_wdata", 0, 0, 0, 0, 2, 2, 0, 0);
`endif
    repeat (3) step;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL pending: got %0d unchecked entries expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
